irq_event_pulser: RTL and testbench



---
 rtl/irq_event_pulser_if.sv | 27 ++
 rtl/irq_event_pulser.sv | 205 ++++++++++++++++++++
 tb/tb_irq_event_pulser.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_event_pulser_if.sv
// -----------------------------------------------------------------------------
// irq_event_pulser_if
// Avalon-MM slave bus bundle for irq_event_pulser.
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           write strobe, active low
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (returned by the slave)
// Modports: master (CPU / bench side), slave (irq_event_pulser side).
// -----------------------------------------------------------------------------
interface irq_event_pulser_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/irq_event_pulser.sv
// -----------------------------------------------------------------------------
// irq_event_pulser
// Collects per-source event strobes into a write-1-to-clear cause register and
// emits one fixed-width high pulse per batch of newly pending causes, followed
// by a guaranteed low gap, for a downstream rising-edge-capturing PIO input.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   src_event  [N_SRC-1:0] per-source event strobes (one event per high cycle)
//   bus        Avalon-MM slave (irq_event_pulser_if.slave)
//   irq_pulse  pulse to the downstream PIO in_port, straight from a flop
//
// Register map (1-cycle read latency, readdata follows address every cycle):
//   0 PENDING  read pending; write 1 clears pending and signalled bits
//   1 ENABLE   R/W per-source enable
//   2 STATUS   bit0 irq_pulse, bits2:1 FSM state, bits 16+: signalled
//   3 COUNT    pulse_count[15:0] when IRQ_PULSE_COUNT_EN is defined, else 0
//
// Optional feature macro: IRQ_PULSE_COUNT_EN
//   Defined:   saturating 16-bit count of pulses, readable at addr3, any write
//              to addr3 clears it.
//   Undefined: no counter is built; addr3 reads 0 and writes are ignored.
// -----------------------------------------------------------------------------
module irq_event_pulser #(
    parameter int N_SRC   = 4,
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_event,
    irq_event_pulser_if.slave    bus,
    output logic                 irq_pulse
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    // The IDLE cycle that launches the next pulse is itself low, so the GAP
    // state only needs GAP_W-1 cycles for the total low time to be GAP_W.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   signalled_q, signalled_d;
    logic [N_SRC-1:0]   enable_q, enable_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               wr_en;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   set_mask;
    logic               new_work;
    logic               go;
    logic               unused_wdata;

    assign wr_en    = bus.chipselect && !bus.write_n;
    assign w1c      = (wr_en && bus.address == 2'd0) ? bus.writedata[N_SRC-1:0] : '0;
    assign set_mask = src_event & enable_q;
    assign new_work = |(pending_q & ~signalled_q);
    assign go       = (state_q == IDLE) && new_work;

    // Upper write-data bits are not decoded by every register.
    assign unused_wdata = ^bus.writedata;

`ifdef IRQ_PULSE_COUNT_EN
    logic [15:0] pulse_count_q, pulse_count_d;

    always_comb begin
        pulse_count_d = pulse_count_q;
        // A write wins over a same-cycle increment.
        if (wr_en && bus.address == 2'd3) begin
            pulse_count_d = '0;
        end else if (go && pulse_count_q != 16'hFFFF) begin
            pulse_count_d = pulse_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_count_q <= '0;
        end else begin
            pulse_count_q <= pulse_count_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    // NOTE: all flops here are control state (no storage arrays), so every
    // one of them is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
            pending_q   <= '0;
            signalled_q <= '0;
            enable_q    <= '0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            signalled_q <= signalled_d;
            enable_q    <= enable_d;
            readdata_q  <= readdata_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (new_work) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output and register-file logic
    // ---------------------------------------------------------------------
    always_comb begin
        // Registered pulse: high exactly while the FSM sits in PULSE.
        irq_d = (state_d == PULSE);

        // Set wins over a same-cycle W1C on the same bit.
        pending_d = (pending_q & ~w1c) | set_mask;

        // The snapshot uses pending_d so events landing in the launch cycle
        // merge into this pulse. A W1C always clears signalled, so a bit that
        // is set again in the same cycle stays unsignalled and fires again.
        signalled_d = (signalled_q | (go ? pending_d : '0)) & ~w1c;

        enable_d = enable_q;
        if (wr_en && bus.address == 2'd1) begin
            enable_d = bus.writedata[N_SRC-1:0];
        end

        readdata_d = '0;
        unique case (bus.address)
            2'd0: readdata_d[N_SRC-1:0] = pending_q;
            2'd1: readdata_d[N_SRC-1:0] = enable_q;
            2'd2: begin
                readdata_d[0]          = irq_q;
                readdata_d[2:1]        = state_q;
                readdata_d[16 +: N_SRC] = signalled_q;
            end
            2'd3: begin
`ifdef IRQ_PULSE_COUNT_EN
                readdata_d[15:0] = pulse_count_q;
`else
                readdata_d = '0;
`endif
            end
            default: readdata_d = '0;
        endcase
    end

    assign irq_pulse    = irq_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_irq_event_pulser.sv
// -----------------------------------------------------------------------------
// tb_irq_event_pulser
// Directed bench for irq_event_pulser (N_SRC=4, PULSE_W=4, GAP_W=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_irq_event_pulser;

    localparam int N_SRC = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_SRC-1:0] src_event = '0;
    logic             irq_pulse;

    irq_event_pulser_if bus ();

    irq_event_pulser #(
        .N_SRC   (N_SRC),
        .PULSE_W (4),
        .GAP_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_event (src_event),
        .bus       (bus),
        .irq_pulse (irq_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        step();
        d = bus.readdata;
    endtask

    // Bounded waits: an expired bound shows up as a failed check.
    task automatic wait_rise(input string tag, input int limit);
        int n = 0;
        while (irq_pulse !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check(tag, {31'd0, irq_pulse}, 32'd1);
    endtask

    task automatic wait_fall(input string tag, input int limit);
        int n = 0;
        while (irq_pulse !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        check(tag, {31'd0, irq_pulse}, 32'd0);
    endtask

    // Samples irq_pulse for n cycles (current one first), returns high count.
    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (irq_pulse === 1'b1) hi++;
            step();
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          hi;
        int          rise1;

        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // ---------------- reset state ----------------
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        check("rst_irq", {31'd0, irq_pulse}, 32'd0);
        bus_read(2'd0, rd); check("rst_pending", rd, 32'h0);
        bus_read(2'd1, rd); check("rst_enable",  rd, 32'h0);
        bus_read(2'd2, rd); check("rst_status",  rd, 32'h0);

        // ---------------- single event ----------------
        bus_write(2'd1, 32'h1);
        src_event = 4'b0001;            // cycle T
        step();
        src_event = '0;                 // T+1
        check("single_t1_low", {31'd0, irq_pulse}, 32'd0);
        bus.address = 2'd2;
        step();                         // T+2
        check("single_rise_t2", {31'd0, irq_pulse}, 32'd1);
        rise1 = cyc;
        step();                         // T+3, readdata shows T+2
        check("status_pulse", bus.readdata, 32'h0001_0003);
        wait_fall("single_fall", 20);   // expected at T+6
        check("single_width", cyc - rise1, 32'd4);
        step();                         // T+7, readdata shows T+6 (GAP)
        check("status_gap", bus.readdata, 32'h0001_0004);
        count_high(7, hi);              // T+7..T+13 must stay low
        check("single_gap_low", hi, 32'd0);
        bus_read(2'd0, rd); check("single_pending",   rd, 32'h1);
        bus_read(2'd2, rd); check("single_signalled", rd, 32'h0001_0000);
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, rd); check("w1c_clear", rd, 32'h0);

        // ---------------- disabled source ----------------
        src_event = 4'b0100;
        step();
        src_event = '0;
        count_high(6, hi);
        check("disabled_no_pulse", hi, 32'd0);
        bus_read(2'd0, rd); check("disabled_pending", rd, 32'h0);

        // ---------------- burst merging ----------------
        bus_write(2'd1, 32'hF);
        src_event = 4'b0010;
        step();
        src_event = 4'b1000;
        step();
        src_event = '0;
        check("burst_rise", {31'd0, irq_pulse}, 32'd1);
        wait_fall("burst_fall", 20);
        count_high(24, hi);
        check("burst_one_pulse", hi, 32'd0);
        bus_read(2'd0, rd); check("burst_pending", rd, 32'hA);
        bus_write(2'd0, 32'hF);

        // ---------------- events during pulse/gap ----------------
        src_event = 4'b0001;
        step();
        src_event = '0;
        wait_rise("repulse_first_rise", 10);
        rise1 = cyc;
        step();                         // second PULSE cycle
        src_event = 4'b0010;
        step();
        src_event = '0;
        bus_write(2'd0, 32'h1);
        wait_fall("repulse_first_fall", 20);
        wait_rise("repulse_second_rise", 30);
        check("repulse_spacing", cyc - rise1, 32'd12);
        bus_write(2'd0, 32'hF);
        wait_fall("repulse_second_fall", 20);
        repeat (10) step();

        // ---------------- W1C / set collision ----------------
        src_event = 4'b0001;
        step();
        src_event = '0;
        wait_rise("coll_prep_rise", 10);
        wait_fall("coll_prep_fall", 20);
        repeat (10) step();             // back in IDLE, bit0 pending+signalled
        bus.address    = 2'd0;
        bus.writedata  = 32'h1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        src_event      = 4'b0001;       // collision cycle C
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        src_event      = '0;
        step();                         // C+2, readdata shows C+1
        check("collision_pending", bus.readdata, 32'h1);
        check("collision_refire", {31'd0, irq_pulse}, 32'd1);

        // ---------------- reset mid-pulse ----------------
        step();                         // second PULSE cycle
        reset = 1'b1;
        step();
        check("reset_mid_pulse", {31'd0, irq_pulse}, 32'd0);
        step();
        reset = 1'b0;
        bus_read(2'd0, rd); check("reset_pending", rd, 32'h0);
        bus_read(2'd1, rd); check("reset_enable",  rd, 32'h0);
        bus_read(2'd2, rd); check("reset_status",  rd, 32'h0);

        // ---------------- pulse counter / addr3 ----------------
`ifdef IRQ_PULSE_COUNT_EN
        bus_write(2'd1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            src_event = 4'b0001;
            step();
            src_event = '0;
            wait_rise("count_rise", 10);
            wait_fall("count_fall", 20);
            bus_write(2'd0, 32'h1);
            repeat (10) step();
        end
        bus_read(2'd3, rd); check("count_three", rd, 32'h3);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd); check("count_cleared", rd, 32'h0);
`else
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd); check("addr3_zero", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
